// File: rtl/hazard_pkg.sv
// Shared defaults and sizing helpers for the register hazard scoreboard.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W    = 4;
    localparam int DEF_LOAD_USE_DIST = 1;
    localparam int DEF_NO_FWD_DIST   = 2;
    localparam int DEF_CNT_W         = 16;

    // Width of a per-register pending counter: enough to hold the larger
    // of the two stall distances. Never narrower than one bit.
    function automatic int pend_width(input int load_use, input int no_fwd);
        int m;
        m = (load_use > no_fwd) ? load_use : no_fwd;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One register's pending-write down-counter. A load sets the distance to
// the producer's write-back; each advancing cycle counts it toward zero.
module scoreboard_entry #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PEND_W-1:0] load_val,
    input  logic              dec,
    output logic              busy
);

    logic [PEND_W-1:0] pend;

    // Load has priority over decrement so a re-issue to the same register
    // restarts its distance instead of losing a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (load) begin
            pend <= load_val;
        end else if (dec && (pend != '0)) begin
            pend <= pend - 1'b1;
        end
    end

    assign busy = (pend != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard scoreboard for a single-issue pipeline. Tracks
// how many cycles each register's producer still needs before a consumer
// in ID may read it, raises hazard to stall IF/ID, and counts stall cycles.
//
// Flow-control contract: an ID instruction (id_valid) moves on when
// pipe_adv=1 and hazard=0; hazard=1 holds it in ID and inserts a bubble;
// pipe_adv=0 freezes everything (no issue, no countdown, no stall count);
// flush discards the ID instruction without touching older entries.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter int LOAD_USE_DIST = DEF_LOAD_USE_DIST,
    parameter int NO_FWD_DIST   = DEF_NO_FWD_DIST,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forward_en,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    src1,
    input  logic [REG_ADDR_W-1:0]    src2,
    input  logic                     two_src,
    input  logic [REG_ADDR_W-1:0]    id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_mem_r_en,
    input  logic                     pipe_adv,
    input  logic                     flush,
    input  logic                     cnt_clr,
    output logic                     hazard,
    output logic [2**REG_ADDR_W-1:0] busy,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int PEND_W   = pend_width(LOAD_USE_DIST, NO_FWD_DIST);

    logic              issue;
    logic [PEND_W-1:0] load_val;

    // Stall when a live ID instruction reads a register still pending.
    always_comb begin
        hazard = id_valid && !flush &&
                 (busy[src1] || (two_src && busy[src2]));
    end

    // An instruction issues only when it leaves ID this cycle and writes.
    always_comb begin
        issue = id_valid && !flush && !hazard && pipe_adv && id_wb_en;
    end

    // Distance the new producer imposes; with forwarding only loads stall.
    always_comb begin
        load_val = '0;
        if (!forward_en) begin
            load_val = PEND_W'(NO_FWD_DIST);
        end else if (id_mem_r_en) begin
            load_val = PEND_W'(LOAD_USE_DIST);
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .PEND_W(PEND_W)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && (id_dest == REG_ADDR_W'(r))),
            .load_val (load_val),
            .dec      (pipe_adv),
            .busy     (busy[r])
        );
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
        end else if (hazard && pipe_adv && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (stall counter narrowed to 4 bits
// so saturation is reachable in a few cycles).
module tb_hazard_scoreboard;

    localparam int AW   = 4;
    localparam int NR   = 2 ** AW;
    localparam int CW   = 4;
    localparam int EW   = 1 + NR + CW;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          forward_en = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] src1 = '0;
    logic [AW-1:0] src2 = '0;
    logic          two_src = 1'b0;
    logic [AW-1:0] id_dest = '0;
    logic          id_wb_en = 1'b0;
    logic          id_mem_r_en = 1'b0;
    logic          pipe_adv = 1'b1;
    logic          flush = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          hazard;
    logic [NR-1:0] busy;
    logic [CW-1:0] stall_count;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .forward_en  (forward_en),
        .id_valid    (id_valid),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .pipe_adv    (pipe_adv),
        .flush       (flush),
        .cnt_clr     (cnt_clr),
        .hazard      (hazard),
        .busy        (busy),
        .stall_count (stall_count)
    );

    // Clock and run-time guard.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle();
        id_valid    = 1'b0;
        id_wb_en    = 1'b0;
        id_mem_r_en = 1'b0;
        two_src     = 1'b0;
        src1        = 4'd15;
        src2        = 4'd15;
        id_dest     = 4'd0;
        flush       = 1'b0;
        cnt_clr     = 1'b0;
        pipe_adv    = 1'b1;
    endtask

    // Producer in ID reading only R15 (never written by this bench).
    task automatic drv_issue(input logic [AW-1:0] dest, input logic is_load);
        drv_idle();
        id_valid    = 1'b1;
        id_wb_en    = 1'b1;
        id_dest     = dest;
        id_mem_r_en = is_load;
    endtask

    // Consumer in ID that does not write a register.
    task automatic drv_use(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic two);
        drv_idle();
        id_valid = 1'b1;
        src1     = s1;
        src2     = s2;
        two_src  = two;
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_out(input logic h, input logic [NR-1:0] b,
                              input logic [CW-1:0] c);
        exp_q.push_back({h, b, c});
    endtask

    task automatic check(input string tag);
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        #1;
        obs = {hazard, busy, stall_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed output with no expectation queued", tag);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed h=%0b busy=%h cnt=%0d expected h=%0b busy=%h cnt=%0d",
                       tag, obs[EW-1], obs[CW +: NR], obs[CW-1:0],
                       exp[EW-1], exp[CW +: NR], exp[CW-1:0]);
            end
        end
    endtask

    task automatic step(input string tag, input logic h,
                        input logic [NR-1:0] b, input logic [CW-1:0] c);
        expect_out(h, b, c);
        check(tag);
        tick();
    endtask

    function automatic logic [NR-1:0] bit_of(input int r);
        logic [NR-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [CW-1:0] ec;
        drv_idle();

        // Reset state
        #2;
        step("reset", 1'b0, '0, '0);
        rst = 1'b0;
        step("post_reset_idle", 1'b0, '0, '0);

        // No forwarding: ADD R3 then consumer of R3 stalls 2 cycles
        forward_en = 1'b0;
        drv_issue(4'd3, 1'b0);
        step("nofwd_issue_r3", 1'b0, '0, 4'd0);
        drv_use(4'd3, 4'd15, 1'b0);
        step("nofwd_stall1", 1'b1, bit_of(3), 4'd0);
        step("nofwd_stall2", 1'b1, bit_of(3), 4'd1);
        step("nofwd_clear", 1'b0, '0, 4'd2);

        // Forwarding: load-use via src2 with two_src=1 stalls one cycle
        forward_en = 1'b1;
        drv_issue(4'd5, 1'b1);
        step("ldr_issue_r5", 1'b0, '0, 4'd2);
        drv_use(4'd15, 4'd5, 1'b1);
        step("ldr_use_src2", 1'b1, bit_of(5), 4'd2);
        step("ldr_use_done", 1'b0, '0, 4'd3);
        // Same but src2 is not a real operand
        drv_issue(4'd5, 1'b1);
        step("ldr_issue_r5b", 1'b0, '0, 4'd3);
        drv_use(4'd15, 4'd5, 1'b0);
        step("ldr_src2_unused", 1'b0, bit_of(5), 4'd3);
        drv_idle();
        step("ldr_drained", 1'b0, '0, 4'd3);

        // Forwarding: ALU result never stalls
        drv_issue(4'd7, 1'b0);
        step("fwd_add_r7", 1'b0, '0, 4'd3);
        drv_use(4'd7, 4'd15, 1'b0);
        step("fwd_use_r7", 1'b0, '0, 4'd3);

        // Memory freeze holds counters and stall count
        forward_en = 1'b0;
        drv_issue(4'd2, 1'b0);
        step("frz_issue_r2", 1'b0, '0, 4'd3);
        drv_use(4'd2, 4'd15, 1'b0);
        pipe_adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("frz_hold", 1'b1, bit_of(2), 4'd3);
        end
        pipe_adv = 1'b1;
        step("frz_resume1", 1'b1, bit_of(2), 4'd3);
        step("frz_resume2", 1'b1, bit_of(2), 4'd4);
        step("frz_done", 1'b0, '0, 4'd5);

        // Clear wins over an increment in the same cycle
        drv_issue(4'd11, 1'b0);
        step("clr_issue_r11", 1'b0, '0, 4'd5);
        drv_use(4'd11, 4'd15, 1'b0);
        cnt_clr = 1'b1;
        step("clr_with_stall", 1'b1, bit_of(11), 4'd5);
        cnt_clr = 1'b0;
        step("clr_after", 1'b1, bit_of(11), 4'd0);
        step("clr_drained", 1'b0, '0, 4'd1);

        // Flush suppresses hazard and issue; older entry keeps counting
        drv_issue(4'd4, 1'b0);
        step("fl_issue_r4", 1'b0, '0, 4'd1);
        drv_issue(4'd9, 1'b0);
        src1  = 4'd4;
        flush = 1'b1;
        step("fl_flush", 1'b0, bit_of(4), 4'd1);
        drv_idle();
        step("fl_dec", 1'b0, bit_of(4), 4'd1);
        step("fl_empty", 1'b0, '0, 4'd1);

        // Reload wins over decrement on the same register
        drv_issue(4'd6, 1'b0);
        step("rl_issue1", 1'b0, '0, 4'd1);
        drv_issue(4'd6, 1'b0);
        step("rl_issue2", 1'b0, bit_of(6), 4'd1);
        drv_idle();
        step("rl_pend2", 1'b0, bit_of(6), 4'd1);
        step("rl_pend1", 1'b0, bit_of(6), 4'd1);
        step("rl_empty", 1'b0, '0, 4'd1);

        // forward_en change does not rewrite an existing entry
        forward_en = 1'b0;
        drv_issue(4'd8, 1'b0);
        step("fm_issue_r8", 1'b0, '0, 4'd1);
        forward_en = 1'b1;
        drv_idle();
        step("fm_pend2", 1'b0, bit_of(8), 4'd1);
        step("fm_pend1", 1'b0, bit_of(8), 4'd1);
        step("fm_empty", 1'b0, '0, 4'd1);

        // Saturation of the stall counter
        forward_en = 1'b0;
        ec = 4'd1;
        for (int k = 0; k < 8; k++) begin
            drv_issue(4'd1, 1'b0);
            step("sat_issue", 1'b0, '0, ec);
            drv_use(4'd1, 4'd15, 1'b0);
            for (int s = 0; s < 2; s++) begin
                step("sat_stall", 1'b1, bit_of(1), ec);
                if (ec != CMAX) ec = ec + 1'b1;
            end
        end
        drv_idle();
        step("sat_hold", 1'b0, '0, CMAX);

        // Asynchronous reset mid-countdown
        drv_issue(4'd10, 1'b0);
        step("rst_issue_r10", 1'b0, '0, CMAX);
        drv_use(4'd10, 4'd15, 1'b0);
        expect_out(1'b1, bit_of(10), CMAX);
        check("rst_before");
        #1;
        rst = 1'b1;
        expect_out(1'b0, '0, '0);
        check("rst_async");
        tick();
        #2;
        rst = 1'b0;
        tick();
        step("rst_empty", 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
